// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: shares one single-port RAM between a write engine and a
// read engine. Ownership is granted per burst, alternates on contention, and
// a watchdog forces a handover after 256 beats without a last flag.
module axi_mem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024,
  localparam int AW          = $clog2(MEMORY_DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  // write engine
  input  logic                  wr_req,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  wr_gnt,
  // read engine
  input  logic                  rd_req,
  input  logic [AW-1:0]         rd_addr,
  input  logic                  rd_last,
  output logic                  rd_gnt,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_valid,
  // single-port RAM, one-cycle read latency
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  // watchdog release indication
  output logic                  burst_abort
);

  // The AXI byte address must at least span the word address of the RAM.
  if (ADDR_WIDTH < AW) begin : g_bad_addr_width
    $error("axi_mem_arbiter: ADDR_WIDTH smaller than RAM word address width");
  end

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WR_BURST = 2'd1;
  localparam logic [1:0] RD_BURST = 2'd2;

  localparam logic SERVED_WRITE = 1'b0;
  localparam logic SERVED_READ  = 1'b1;

  // The 256th beat of a burst is the last one the watchdog allows.
  localparam logic [8:0] WD_LAST_CNT = 9'd255;

  logic [1:0]            state, state_nxt;
  logic                  last_served, last_served_nxt;
  logic [8:0]            beat_cnt;
  logic                  burst_end, abort_nxt;
  logic                  wr_acc, rd_acc;
  logic                  wd_hit;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Grants decode directly from the state register, so they are glitch-free
  // and drop the instant reset forces IDLE.
  assign wr_gnt = (state == WR_BURST);
  assign rd_gnt = (state == RD_BURST);

  // A beat is accepted only by the current owner; the other side's request
  // never gates anything during a burst.
  assign wr_acc = wr_gnt && wr_req;
  assign rd_acc = rd_gnt && rd_req;
  assign wd_hit = (beat_cnt == WD_LAST_CNT);

  // Memory port steering: idle cycles drive zeros on address and data.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/case can leave it unassigned and infer a latch.
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (wr_acc) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else if (rd_acc) begin
      mem_en   = 1'b1;
      mem_addr = rd_addr;
    end
  end

  // Arbitration and burst-end decisions, including direct handover.
  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    burst_end       = 1'b0;
    abort_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req && (!rd_req || last_served == SERVED_READ)) begin
          state_nxt = WR_BURST;
        end else if (rd_req) begin
          state_nxt = RD_BURST;
        end
      end
      WR_BURST: begin
        if (wr_acc && (wr_last || wd_hit)) begin
          burst_end       = 1'b1;
          abort_nxt       = !wr_last;
          last_served_nxt = SERVED_WRITE;
          state_nxt       = rd_req ? RD_BURST : IDLE;
        end
      end
      RD_BURST: begin
        if (rd_acc && (rd_last || wd_hit)) begin
          burst_end       = 1'b1;
          abort_nxt       = !rd_last;
          last_served_nxt = SERVED_READ;
          state_nxt       = wr_req ? WR_BURST : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, fairness flag, per-burst beat counter, abort pulse.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state       <= IDLE;
      last_served <= SERVED_READ;
      beat_cnt    <= '0;
      burst_abort <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state       <= state_nxt;
      last_served <= last_served_nxt;
      burst_abort <= abort_nxt;
      if (burst_end || state == IDLE) begin
        beat_cnt <= '0;
      end else if (wr_acc || rd_acc) begin
        beat_cnt <= beat_cnt + 9'd1;
      end
    end
  end

  // Read return path: valid one cycle after an accepted read beat, and the
  // last returned word is kept for the cycles in between.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_data_valid <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      rd_data_valid <= rd_acc;
      if (rd_data_valid) begin
        rd_data_q <= mem_rdata;
      end
    end
  end

  assign rd_data = rd_data_valid ? mem_rdata : rd_data_q;

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb_axi_mem_arbiter: table-driven arbitration vectors plus hand-written
// burst sequences; read data is checked against a queue of expected words.
module tb_axi_mem_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          wr_req, wr_last, rd_req, rd_last;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt, rd_gnt, rd_data_valid, burst_abort;
  logic [DW-1:0] rd_data;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] sb [$];

  axi_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(16), .MEMORY_DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_last(rd_last), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .burst_abort(burst_abort)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [DW-1:0] init_word(int i);
    return (i == DEPTH - 1) ? 32'hDEAD_BEEF : 32'h1000_0000 + i;
  endfunction

  // Behavioural single-port RAM with one-cycle read latency.
  logic [DW-1:0] ram [DEPTH];
  bit            ram_ready = 1'b0;
  always @(posedge ACLK) begin
    if (!ram_ready) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Scoreboard consumer: every returned read word must match the next expected.
  always @(negedge ACLK) begin
    if (ARESETn && rd_data_valid) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        check("sb_rd_data", rd_data, sb.pop_front());
      end
    end
  end

  typedef struct packed {
    bit wr_req, wr_last, rd_req, rd_last;
    bit e_wgnt, e_rgnt, e_en, e_we, e_rvalid;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int errs;
    vecs = '{
      '{1,0,1,0, 0,0,0,0,0},  // both request from reset: idle this cycle
      '{1,0,1,0, 1,0,1,1,0},  // write wins first
      '{0,0,1,0, 1,0,0,0,0},  // write stalls, read pending
      '{0,0,1,0, 1,0,0,0,0},
      '{0,0,1,0, 1,0,0,0,0},
      '{1,1,1,0, 1,0,1,1,0},  // write last -> read next, no idle
      '{1,0,1,0, 0,1,1,0,0},  // write request ignored during read
      '{1,0,1,1, 0,1,1,0,1},  // read last -> write next
      '{0,0,0,0, 1,0,0,0,1},
      '{1,1,0,0, 1,0,1,1,0},  // write last, nothing pending -> idle
      '{0,0,0,0, 0,0,0,0,0},
      '{1,0,1,1, 0,0,0,0,0},  // contention after write -> read wins
      '{1,0,1,1, 0,1,1,0,0},
      '{0,0,0,0, 1,0,0,0,1},
      '{1,1,0,0, 1,0,1,1,0},
      '{0,0,0,0, 0,0,0,0,0}
    };
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_word(i);

    ARESETn = 1'b0;
    wr_req = 0; wr_last = 0; rd_req = 0; rd_last = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    #2;
    check("rst_wr_gnt", 32'(wr_gnt), 0);
    check("rst_rd_gnt", 32'(rd_gnt), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", 32'(rd_data_valid), 0);
    check("rst_abort", 32'(burst_abort), 0);
    tick(); tick();
    ARESETn = 1'b1;
    tick();

    // Table-driven arbitration, stall and handover vectors.
    for (int r = 0; r < 16; r++) begin
      logic [AW-1:0] e_addr;
      wr_req  = vecs[r].wr_req;  wr_last = vecs[r].wr_last;
      rd_req  = vecs[r].rd_req;  rd_last = vecs[r].rd_last;
      wr_addr = AW'(10'h100 + r); wr_data = 32'hC000_0000 + r;
      rd_addr = AW'(10'h020 + r);
      #1;
      e_addr = vecs[r].e_en ? (vecs[r].e_we ? wr_addr : rd_addr) : '0;
      check($sformatf("vec%0d_wr_gnt", r), 32'(wr_gnt), 32'(vecs[r].e_wgnt));
      check($sformatf("vec%0d_rd_gnt", r), 32'(rd_gnt), 32'(vecs[r].e_rgnt));
      check($sformatf("vec%0d_mem_en", r), 32'(mem_en), 32'(vecs[r].e_en));
      check($sformatf("vec%0d_mem_we", r), 32'(mem_we), 32'(vecs[r].e_we));
      check($sformatf("vec%0d_mem_addr", r), 32'(mem_addr), 32'(e_addr));
      check($sformatf("vec%0d_rd_valid", r), 32'(rd_data_valid), 32'(vecs[r].e_rvalid));
      if (vecs[r].e_en && vecs[r].e_we) exp_mem[wr_addr] = wr_data;
      if (vecs[r].e_en && !vecs[r].e_we) sb.push_back(exp_mem[rd_addr]);
      tick();
    end

    // Four-beat write burst at 0x010..0x013.
    wr_req = 1; wr_last = 0; wr_addr = 10'h010; wr_data = 32'hA0;
    #1 check("wb_req_cycle_gnt", 32'(wr_gnt), 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      wr_addr = AW'(10'h010 + b); wr_data = 32'hA0 + b; wr_last = (b == 3);
      #1;
      check($sformatf("wb%0d_gnt", b), 32'(wr_gnt), 1);
      check($sformatf("wb%0d_we", b), 32'(mem_we), 1);
      check($sformatf("wb%0d_addr", b), 32'(mem_addr), 32'h010 + b);
      check($sformatf("wb%0d_wdata", b), mem_wdata, 32'hA0 + b);
      exp_mem[wr_addr] = wr_data;
      tick();
    end
    wr_req = 0; wr_last = 0;
    #1;
    check("wb_end_gnt", 32'(wr_gnt), 0);
    check("wb_end_en", 32'(mem_en), 0);

    // Read the burst back through the scoreboard.
    rd_req = 1; rd_last = 0;
    tick();
    for (int b = 0; b < 4; b++) begin
      rd_addr = AW'(10'h010 + b); rd_last = (b == 3);
      sb.push_back(exp_mem[rd_addr]);
      tick();
    end
    rd_req = 0; rd_last = 0;
    tick(); tick();

    // Read of the top word: data returns exactly one cycle later, then holds.
    rd_req = 1; rd_last = 1; rd_addr = 10'h3FF;
    tick();
    check("top_rd_gnt", 32'(rd_gnt), 1);
    check("top_rd_addr", 32'(mem_addr), 32'h3FF);
    sb.push_back(exp_mem[10'h3FF]);
    tick();
    rd_req = 0; rd_last = 0;
    #1;
    check("top_rd_valid", 32'(rd_data_valid), 1);
    check("top_rd_data", rd_data, 32'hDEAD_BEEF);
    tick();
    check("top_rd_valid_drop", 32'(rd_data_valid), 0);
    check("top_rd_data_hold", rd_data, 32'hDEAD_BEEF);

    // Watchdog: 256 write beats without last while a read waits.
    wr_req = 1; wr_last = 0; rd_req = 1; rd_last = 1; rd_addr = 10'h3FF;
    tick();
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      wr_addr = AW'(i); wr_data = 32'h5000_0000 + i;
      exp_mem[wr_addr] = wr_data;
      #1;
      if (!(wr_gnt && mem_en && mem_we && !burst_abort && !rd_gnt)) errs++;
      tick();
    end
    check("wd_beats_ok", 32'(errs), 0);
    wr_req = 0;
    sb.push_back(exp_mem[10'h3FF]);
    #1;
    check("wd_abort", 32'(burst_abort), 1);
    check("wd_wr_gnt", 32'(wr_gnt), 0);
    check("wd_rd_gnt", 32'(rd_gnt), 1);
    check("wd_rd_beat_we", 32'(mem_we), 0);
    tick();
    rd_req = 0; rd_last = 0;
    #1;
    check("wd_abort_pulse", 32'(burst_abort), 0);
    check("wd_rd_done", 32'(rd_gnt), 0);
    tick(); tick();
    check("wd_written", exp_mem[10'h0FF], 32'h5000_00FF);

    // Reset during beat 2 of a read burst.
    rd_req = 1; rd_last = 0; rd_addr = 10'h050;
    tick();
    tick();
    ARESETn = 1'b0;
    #1;
    check("ar_rd_gnt", 32'(rd_gnt), 0);
    check("ar_mem_en", 32'(mem_en), 0);
    check("ar_mem_addr", 32'(mem_addr), 0);
    check("ar_rd_valid", 32'(rd_data_valid), 0);
    check("ar_rd_data", rd_data, 0);
    check("ar_abort", 32'(burst_abort), 0);
    tick();
    ARESETn = 1'b1;
    #1 check("ar_idle_after_release", 32'(rd_gnt), 0);
    tick();
    check("ar_regrant", 32'(rd_gnt), 1);
    check("ar_regrant_en", 32'(mem_en), 1);
    rd_last = 1;
    sb.push_back(exp_mem[10'h050]);
    tick();
    rd_req = 0; rd_last = 0;
    tick(); tick();

    check("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_mem_arbiter.md
AXI_MEM_ARBITER -- requirements
Module: axi_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, AXI byte-address width (informational; not used in datapath).
REQ-003 SHALL have parameter MEMORY_DEPTH, default 1024, words; AW = $clog2(MEMORY_DEPTH).
REQ-004 SHALL have port ACLK input 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port ARESETn input 1, asynchronous active-low reset.
REQ-006 SHALL have port wr_req input 1, write engine requests a beat.
REQ-007 SHALL have port wr_addr input AW, write word address.
REQ-008 SHALL have port wr_data input DATA_WIDTH, write beat data.
REQ-009 SHALL have port wr_last input 1, final beat of write burst.
REQ-010 SHALL have port wr_gnt output 1, write engine owns memory.
REQ-011 SHALL have port rd_req input 1, read engine requests a beat.
REQ-012 SHALL have port rd_addr input AW, read word address.
REQ-013 SHALL have port rd_last input 1, final beat of read burst.
REQ-014 SHALL have port rd_gnt output 1, read engine owns memory.
REQ-015 SHALL have port rd_data output DATA_WIDTH, returned read data.
REQ-016 SHALL have port rd_data_valid output 1, rd_data valid this cycle.
REQ-017 SHALL have ports mem_en, mem_we output 1 each; mem_addr output AW; mem_wdata output DATA_WIDTH; mem_rdata input DATA_WIDTH (single-port RAM, 1-cycle read latency).
REQ-018 SHALL have port burst_abort output 1, one-cycle pulse on watchdog release.

Function
REQ-019 SHALL implement FSM states IDLE, WR_BURST, RD_BURST; wr_gnt=1 iff WR_BURST, rd_gnt=1 iff RD_BURST (registered).
REQ-020 SHALL, in IDLE with one request, enter that requester's burst state next cycle.
REQ-021 SHALL, in IDLE with both requests, grant the requester not last served; last_served resets to READ so write wins first.
REQ-022 SHALL treat a beat as accepted when gnt && req in the same cycle; mem_en=1 only on accepted beats, combinational.
REQ-023 SHALL drive on write beat: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data; on read beat mem_we=0, mem_addr=rd_addr.
REQ-024 SHALL drive mem_addr, mem_wdata to 0 when no beat is accepted.
REQ-025 SHALL assert rd_data_valid exactly 1 cycle after an accepted read beat, rd_data=mem_rdata in that cycle; rd_data holds last value otherwise.
REQ-026 SHALL hold grant while owner deasserts req mid-burst (stall; no memory access, no release).
REQ-027 SHALL, on accepted beat with last=1, update last_served and: if other requester's req=1, go directly to its burst state; else go IDLE. No dead cycle on handover.
REQ-028 SHALL count accepted beats per burst in 9-bit beat_cnt, cleared on grant entry.
REQ-029 SHALL, if 256 beats accepted without last (beat_cnt reaches 256), release grant as if last, pulse burst_abort 1 cycle, apply REQ-027 handover.
REQ-030 SHALL ignore the non-owner's req entirely during a burst; its inputs never reach memory.

Reset
REQ-031 SHALL, on ARESETn low at any time, immediately force state IDLE, wr_gnt=rd_gnt=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0, rd_data=0, rd_data_valid=0, burst_abort=0, beat_cnt=0, last_served=READ.
REQ-032 SHALL resume arbitration on first rising ACLK after ARESETn deasserts; a burst interrupted by reset is not resumed.

Verification
REQ-033 SHALL verify: write-only burst, 4 beats, addr 0x010..0x013, data 0xA0..0xA3 -> wr_gnt 1 cycle after req, 4 cycles mem_we=1, IDLE after last.
REQ-034 SHALL verify: wr_req and rd_req rise same cycle after reset -> write granted first; on write last, rd_gnt=1 next cycle, no IDLE cycle.
REQ-035 SHALL verify: read beat at addr 0x3FF with mem_rdata=0xDEADBEEF -> rd_data_valid=1 with rd_data=0xDEADBEEF one cycle after beat.
REQ-036 SHALL verify: write owner drops wr_req 3 cycles mid-burst while rd_req=1 -> wr_gnt held, mem_en=0 those cycles, rd_gnt stays 0.
REQ-037 SHALL verify: 256 write beats with wr_last=0 -> burst_abort pulses once, wr_gnt drops, pending read granted next cycle.
REQ-038 SHALL verify: ARESETn low during beat 2 of a read burst -> all outputs 0 without waiting for ACLK; after release, rd_req regranted from IDLE.
